// File: rtl/uartrx.sv
// uartrx: 16x-oversampled UART receiver, 8 data bits with an optional parity bit.
// It recovers frames from an asynchronous rx line using the shared clk_bd enable.
// A good byte produces a one-clock rdsig pulse. Stop-bit and parity failures
// produce one-clock frame_err and par_err pulses.
module uartrx #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_bd,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       rdsig,
  output logic       frame_err,
  output logic       par_err,
  output logic       busy
);

  localparam int            CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 2);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam bit            PEN      = (PARITY_EN != 0);
  localparam bit            PODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    samp_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          par_bad_q;
  logic [7:0]    dataout_q;
  logic          rdsig_q, frame_err_q, par_err_q, busy_q;

  logic start_det;
  logic tick_mid;
  logic tick_last;
  logic vote;
  logic par_exp;

  // Two-flop synchronizer on rx plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // Decode the bit-timing points and the 2-of-3 vote over the mid-bit samples.
  always_comb begin
    start_det = rx_s3_q & ~rx_s2_q;
    tick_mid  = clk_bd && (cnt_q == CNT_MID);
    tick_last = clk_bd && (cnt_q == CNT_LAST);
    vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
    par_exp   = (^shift_q) ^ PODD;
  end

  // Frame FSM with its tick counter, shift register and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      samp_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      dataout_q   <= '0;
      rdsig_q     <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Pulses last exactly one clock unless re-asserted below.
      rdsig_q     <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;

      // The bit clock runs only while a frame is in progress. The counter wraps
      // at each bit boundary, and the first two vote samples are taken just
      // before mid-bit.
      if (clk_bd && state_q != S_IDLE && state_q != S_BREAK) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CNT_S0) samp_q[0] <= rx_s2_q;
        if (cnt_q == CNT_S1) samp_q[1] <= rx_s2_q;
      end

      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (start_det) begin
            state_q   <= S_START;
            busy_q    <= 1'b1;
            bit_idx_q <= '0;
            par_bad_q <= 1'b0;
          end
        end

        S_START: begin
          // If the line is high again at mid-bit, the falling edge was a glitch.
          if (tick_mid && vote) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (tick_last) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
          end
        end

        S_DATA: begin
          if (tick_mid) shift_q <= {vote, shift_q[7:1]};
          if (tick_last) begin
            if (bit_idx_q == 3'd7) state_q <= PEN ? S_PARITY : S_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end
        end

        S_PARITY: begin
          if (tick_mid)  par_bad_q <= vote ^ par_exp;
          if (tick_last) state_q   <= S_STOP;
        end

        S_STOP: begin
          // Decide at mid stop bit so a following start edge is never missed.
          if (tick_mid) begin
            dataout_q <= shift_q;
            if (vote) begin
              if (par_bad_q) par_err_q <= 1'b1;
              else           rdsig_q   <= 1'b1;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              par_err_q   <= par_bad_q;
              state_q     <= S_BREAK;
            end
          end
        end

        S_BREAK: begin
          // Hold off until the line returns to idle, so a break reports only once.
          cnt_q <= '0;
          if (rx_s2_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dataout   = dataout_q;
  assign rdsig     = rdsig_q;
  assign frame_err = frame_err_q;
  assign par_err   = par_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uartrx.sv
// tb_uartrx: scoreboard bench for uartrx, one 8N1 instance and one even-parity instance.
module tb_uartrx;

  localparam int BD_DIV = 8;            // clk per clk_bd tick
  localparam int BT     = 16 * BD_DIV;  // nominal bit time in clk

  typedef struct packed {
    logic [2:0] kind;   // {rdsig, par_err, frame_err}
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_bd = 1'b0;
  logic       rx0 = 1'b1;
  logic       rxp = 1'b1;
  logic [7:0] d0, dp;
  logic       rd0, fe0, pe0, busy0;
  logic       rdp, fep, pep, busyp;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int bd_cnt = 0;
  int t_start = 0;
  int rd0_cyc = 0;
  ev_t q0[$];
  ev_t qp[$];
  logic [2:0] prev0 = '0;
  logic [2:0] prevp = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_cnt == BD_DIV - 1) begin
      bd_cnt <= 0;
      clk_bd <= 1'b1;
    end else begin
      bd_cnt <= bd_cnt + 1;
      clk_bd <= 1'b0;
    end
  end

  uartrx #(.OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clk_bd(clk_bd), .rx(rx0),
    .dataout(d0), .rdsig(rd0), .frame_err(fe0), .par_err(pe0), .busy(busy0)
  );

  uartrx #(.OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dutp (
    .clk(clk), .rst_n(rst_n), .clk_bd(clk_bd), .rx(rxp),
    .dataout(dp), .rdsig(rdp), .frame_err(fep), .par_err(pep), .busy(busyp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for the 8N1 instance.
  always @(negedge clk) begin
    if (rd0 | fe0 | pe0) begin
      if (q0.size() == 0) begin
        chk("unexp0", {29'd0, rd0, pe0, fe0}, 32'd0);
      end else begin
        chk("kind0", {29'd0, rd0, pe0, fe0}, {29'd0, q0[0].kind});
        chk("data0", {24'd0, d0}, {24'd0, q0[0].data});
        if (rd0) chk("busy_at_rd0", {31'd0, busy0}, 32'd0);
        q0.delete(0);
      end
      chk("width0", {29'd0, prev0}, 32'd0);
      if (rd0) rd0_cyc <= cyc;
    end
    prev0 <= {rd0, pe0, fe0};
  end

  // Scoreboard for the parity instance.
  always @(negedge clk) begin
    if (rdp | fep | pep) begin
      if (qp.size() == 0) begin
        chk("unexpp", {29'd0, rdp, pep, fep}, 32'd0);
      end else begin
        chk("kindp", {29'd0, rdp, pep, fep}, {29'd0, qp[0].kind});
        chk("datap", {24'd0, dp}, {24'd0, qp[0].data});
        qp.delete(0);
      end
      chk("widthp", {29'd0, prevp}, 32'd0);
    end
    prevp <= {rdp, pep, fep};
  end

  task automatic drive(input bit which, input logic v, input int n);
    if (which) rxp = v;
    else       rx0 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pbit < 0 means no parity bit.
  task automatic send(input bit which, input logic [7:0] d, input int bt,
                      input int pbit, input logic stopv);
    drive(which, 1'b0, bt);
    for (int i = 0; i < 8; i++) drive(which, d[i], bt);
    if (pbit >= 0) drive(which, pbit[0], bt);
    drive(which, stopv, bt);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_d0"}, {24'd0, d0}, 32'd0);
    chk({tag, "_dp"}, {24'd0, dp}, 32'd0);
    chk({tag, "_flags0"}, {28'd0, rd0, fe0, pe0, busy0}, 32'd0);
    chk({tag, "_flagsp"}, {28'd0, rdp, fep, pep, busyp}, 32'd0);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk_outs_zero("rst");
    rst_n = 1'b1;
    drive(0, 1'b1, 50);

    // 1: single 0x55 frame, latency and busy checks
    q0.push_back('{kind: 3'b100, data: 8'h55});
    t_start = cyc;
    fork
      send(0, 8'h55, BT, -1, 1'b1);
      begin
        repeat (BT * 4) @(posedge clk);
        #1;
        chk("busy_mid", {31'd0, busy0}, 32'd1);
      end
    join
    drive(0, 1'b1, BT);
    chk("lat_ok", {31'd0, (rd0_cyc - t_start >= 1200) && (rd0_cyc - t_start <= 1250)}, 32'd1);
    chk("busy_idle", {31'd0, busy0}, 32'd0);

    // 2: back-to-back frames at 2% fast baud
    q0.push_back('{kind: 3'b100, data: 8'hA3});
    q0.push_back('{kind: 3'b100, data: 8'h00});
    q0.push_back('{kind: 3'b100, data: 8'hFF});
    send(0, 8'hA3, 125, -1, 1'b1);
    send(0, 8'h00, 125, -1, 1'b1);
    send(0, 8'hFF, 125, -1, 1'b1);
    drive(0, 1'b1, BT);
    chk("b2b_drain", q0.size(), 32'd0);

    // 3: short low glitch must not start a frame
    drive(0, 1'b0, 30);
    chk("glitch_busy", {31'd0, busy0}, 32'd1);
    drive(0, 1'b1, 100);
    chk("glitch_idle", {31'd0, busy0}, 32'd0);
    drive(0, 1'b1, BT);

    // 4: stop bit low then held in break, then recovery
    q0.push_back('{kind: 3'b001, data: 8'h3C});
    send(0, 8'h3C, BT, -1, 1'b0);
    drive(0, 1'b0, 4 * BT);
    chk("break_busy", {31'd0, busy0}, 32'd1);
    drive(0, 1'b1, 20);
    chk("break_exit", {31'd0, busy0}, 32'd0);
    drive(0, 1'b1, BT);
    q0.push_back('{kind: 3'b100, data: 8'h81});
    send(0, 8'h81, BT, -1, 1'b1);
    drive(0, 1'b1, BT);

    // 5: even parity instance
    qp.push_back('{kind: 3'b100, data: 8'h07});
    send(1, 8'h07, BT, 1, 1'b1);
    drive(1, 1'b1, BT);
    qp.push_back('{kind: 3'b010, data: 8'h07});
    send(1, 8'h07, BT, 0, 1'b1);
    drive(1, 1'b1, BT);
    qp.push_back('{kind: 3'b100, data: 8'h00});
    send(1, 8'h00, BT, 0, 1'b1);
    drive(1, 1'b1, BT);
    qp.push_back('{kind: 3'b011, data: 8'hE1});
    send(1, 8'hE1, BT, 1, 1'b0);
    drive(1, 1'b1, BT);
    chk("par_busy", {31'd0, busyp}, 32'd0);

    // 6: reset mid-data; released late in bit 7 so the re-armed start votes high
    fork
      send(0, 8'h5A, BT, -1, 1'b1);
      begin
        repeat (450) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs_zero("midrst");
        repeat (1122 - 450) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    drive(0, 1'b1, 2 * BT);
    chk("rst_nopulse", q0.size(), 32'd0);
    q0.push_back('{kind: 3'b100, data: 8'h5A});
    send(0, 8'h5A, BT, -1, 1'b1);
    drive(0, 1'b1, 2 * BT);

    chk("sb_empty0", q0.size(), 32'd0);
    chk("sb_emptyp", qp.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
